// File: rtl/board_cond_pkg.sv
// Shared types and helpers for the board input conditioner.
package board_cond_pkg;

  typedef enum logic [0:0] {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_e;

  // Counter width for a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Synchronizer plus stability-count debouncer for one asynchronous input,
// with registered one-cycle rise/fall pulses on the accepted level.
module input_debouncer
  import board_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             q_prev;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_i};
    end
  end

  // The counter is cleared at its terminal value, so it can never wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= 1'b0;
      cnt <= '0;
    end else if (s == q_o) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      q_o <= ~q_o;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // q_prev resets together with q_o, so an async reset never produces a fall pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_prev <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      q_prev <= q_o;
      rise_o <= q_o & ~q_prev;
      fall_o <= ~q_o & q_prev;
    end
  end

endmodule

// File: rtl/board_input_conditioner.sv
// Debounces board switches/buttons and stretches the reset pushbutton into a
// release-safe active-low system reset.
//
// state | meaning
// HOLD  | rst_no low; hcnt counts released-button cycles, cleared while pressed
// RUN   | rst_no high; a debounced press returns to HOLD
module board_input_conditioner
  import board_cond_pkg::*;
#(
  parameter int unsigned N_IN            = 12,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RST_HOLD_CYCLES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pad_reset_i,
  input  logic [N_IN-1:0] raw_i,
  output logic [N_IN-1:0] deb_o,
  output logic [N_IN-1:0] rise_o,
  output logic [N_IN-1:0] fall_o,
  output logic            rst_no,
  output logic            rst_btn_o
);

  localparam int unsigned HCNT_W = cnt_width(RST_HOLD_CYCLES);

  logic [N_IN:0]    din;
  logic [N_IN:0]    q_all;
  logic [N_IN:0]    rise_all;
  logic [N_IN:0]    fall_all;
  logic             unused_btn_edges;
  rst_state_e       state;
  logic [HCNT_W-1:0] hcnt;

  assign din = {pad_reset_i, raw_i};

  for (genvar i = 0; i <= N_IN; i++) begin : g_deb
    input_debouncer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (din[i]),
      .q_o   (q_all[i]),
      .rise_o(rise_all[i]),
      .fall_o(fall_all[i])
    );
  end

  assign deb_o            = q_all[N_IN-1:0];
  assign rise_o           = rise_all[N_IN-1:0];
  assign fall_o           = fall_all[N_IN-1:0];
  assign rst_btn_o        = q_all[N_IN];
  assign unused_btn_edges = rise_all[N_IN] ^ fall_all[N_IN];

  // rst_no is a flop reset value, so assertion is async and release is clocked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= HOLD;
      hcnt   <= '0;
      rst_no <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (rst_btn_o) begin
            hcnt <= '0;
          end else if (hcnt == HCNT_W'(RST_HOLD_CYCLES - 1)) begin
            state  <= RUN;
            hcnt   <= '0;
            rst_no <= 1'b1;
          end else begin
            hcnt <= hcnt + HCNT_W'(1);
          end
        end
        RUN: begin
          if (rst_btn_o) begin
            state  <= HOLD;
            hcnt   <= '0;
            rst_no <= 1'b0;
          end
        end
        default: begin
          state  <= HOLD;
          hcnt   <= '0;
          rst_no <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner with short debounce/hold settings.
module tb_board_input_conditioner;

  localparam int unsigned N_IN = 12;

  logic            clk_i;
  logic            rst_ni;
  logic            pad_reset_i;
  logic [N_IN-1:0] raw_i;
  logic [N_IN-1:0] deb_o;
  logic [N_IN-1:0] rise_o;
  logic [N_IN-1:0] fall_o;
  logic            rst_no;
  logic            rst_btn_o;

  int n_checks = 0;
  int n_fail   = 0;

  board_input_conditioner #(
    .N_IN           (N_IN),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .RST_HOLD_CYCLES(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .pad_reset_i(pad_reset_i),
    .raw_i      (raw_i),
    .deb_o      (deb_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .rst_no     (rst_no),
    .rst_btn_o  (rst_btn_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    pad_reset_i = 1'b0;
    raw_i       = '0;

    // Power-up
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_rst_no", 32'(rst_no), 32'd0);
    chk("rst_deb", 32'(deb_o), 32'd0);
    chk("rst_rise", 32'(rise_o), 32'd0);
    chk("rst_fall", 32'(fall_o), 32'd0);
    chk("rst_btn", 32'(rst_btn_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      edge_sample();
      chk("pwr_rst_no", 32'(rst_no), (k == 8) ? 32'd1 : 32'd0);
      chk("pwr_deb", 32'(deb_o), 32'd0);
      chk("pwr_pulses", 32'(rise_o | fall_o), 32'd0);
    end

    // Clean step on bit 3
    @(negedge clk_i);
    raw_i[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      edge_sample();
      chk("step_deb", 32'(deb_o), (k >= 6) ? 32'h008 : 32'h000);
      chk("step_rise", 32'(rise_o), (k == 7) ? 32'h008 : 32'h000);
      chk("step_fall", 32'(fall_o), 32'h000);
    end

    // Bounce on bit 0, then settle low
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      raw_i[0] = (c < 20) ? ~c[1] : 1'b0;
      edge_sample();
      chk("bounce_deb", 32'(deb_o), 32'h008);
      chk("bounce_pulses", 32'(rise_o | fall_o), 32'h000);
    end

    // Button reset while running
    @(negedge clk_i);
    pad_reset_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      edge_sample();
      chk("press_rst_no", 32'(rst_no), (k < 7) ? 32'd1 : 32'd0);
      chk("press_btn", 32'(rst_btn_o), (k >= 6) ? 32'd1 : 32'd0);
    end
    @(negedge clk_i);
    pad_reset_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      edge_sample();
      chk("release_btn", 32'(rst_btn_o), (k < 6) ? 32'd1 : 32'd0);
      chk("release_rst_no", 32'(rst_no), (k >= 14) ? 32'd1 : 32'd0);
    end

    // Clear bit 3, then step all bits together
    @(negedge clk_i);
    raw_i = '0;
    for (int k = 1; k <= 10; k++) begin
      edge_sample();
      chk("clear_fall", 32'(fall_o), (k == 7) ? 32'h008 : 32'h000);
    end
    chk("clear_deb", 32'(deb_o), 32'h000);
    @(negedge clk_i);
    raw_i = 12'hFFF;
    for (int k = 1; k <= 8; k++) begin
      edge_sample();
      chk("all_deb", 32'(deb_o), (k >= 6) ? 32'hFFF : 32'h000);
      chk("all_rise", 32'(rise_o), (k == 7) ? 32'hFFF : 32'h000);
      chk("all_fall", 32'(fall_o), 32'h000);
    end
    chk("all_rst_no", 32'(rst_no), 32'd1);

    // Async reset mid-operation
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_no", 32'(rst_no), 32'd0);
    chk("async_deb", 32'(deb_o), 32'h000);
    chk("async_pulses", 32'(rise_o | fall_o), 32'h000);
    for (int k = 1; k <= 2; k++) begin
      edge_sample();
      chk("inrst_fall", 32'(fall_o), 32'h000);
      chk("inrst_rst_no", 32'(rst_no), 32'd0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      edge_sample();
      chk("redeb_deb", 32'(deb_o), (k >= 6) ? 32'hFFF : 32'h000);
      chk("redeb_rise", 32'(rise_o), (k == 7) ? 32'hFFF : 32'h000);
      chk("redeb_fall", 32'(fall_o), 32'h000);
      chk("redeb_rst_no", 32'(rst_no), (k >= 8) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
